bus_arbiter4: RTL and testbench

//  4-requester bus arbiter owning the shared bus grant. Samples request lines,

---
 rtl/arb_pkg.sv | 29 ++
 rtl/arb_prio_enc4.sv | 18 +
 rtl/bus_arbiter4.sv | 102 ++++++++++
 tb/tb_bus_arbiter4.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared definitions for the 4-requester bus arbiter: requester count, FSM
// state encodings and one-hot/index conversion helpers.
package arb_pkg;

    localparam int NREQ = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    function automatic logic [NREQ-1:0] idx_to_onehot(input logic [1:0] idx);
        logic [NREQ-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

    function automatic logic [1:0] onehot_to_idx(input logic [NREQ-1:0] oh);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < NREQ; i++) begin
            if (oh[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/arb_prio_enc4.sv
// Combinational 4->2 priority encoder, bit 0 highest priority.
// Index reads 0 when no input is set; qualify it with o_valid.
module arb_prio_enc4 (
    input  logic [3:0] i_req,
    output logic [1:0] o_idx,
    output logic       o_valid
);

    always_comb begin
        o_valid = |i_req;
        if (i_req[0])      o_idx = 2'd0;
        else if (i_req[1]) o_idx = 2'd1;
        else if (i_req[2]) o_idx = 2'd2;
        else if (i_req[3]) o_idx = 2'd3;
        else               o_idx = 2'd0;
    end

endmodule

// File: rtl/bus_arbiter4.sv
// 4-requester bus arbiter: fixed or round-robin winner select, grant held until
// release or timeout, then a one-cycle turnaround gap with all grants low.
module bus_arbiter4
    import arb_pkg::*;
#(
    parameter int TIMEOUT = 15,
    parameter bit ROTATE  = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] Req,
    output logic [NREQ-1:0] Grant,
    output logic [1:0]      Y,
    output logic            V,
    output logic            Timeout_Err
);

    // Counter keeps at least one bit so a disabled timeout still elaborates.
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [CW-1:0] TO_CNT  = CW'(TIMEOUT);

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [1:0]      r_ptr;

    logic [1:0]      w_ptr;
    logic [NREQ-1:0] w_rot;
    logic [1:0]      w_enc_idx;
    logic            w_valid;
    logic [1:0]      w_win;

    assign w_ptr = ROTATE ? r_ptr : 2'd0;

    // Rotate right by the pointer so the requester at ptr lands on bit 0.
    for (genvar g = 0; g < NREQ; g++) begin : g_rot
        assign w_rot[g] = Req[w_ptr + 2'(g)];
    end

    arb_prio_enc4 u_enc (
        .i_req   (w_rot),
        .o_idx   (w_enc_idx),
        .o_valid (w_valid)
    );

    assign w_win = w_ptr + w_enc_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_ptr       <= 2'd0;
            Grant       <= '0;
            Y           <= 2'd0;
            V           <= 1'b0;
            Timeout_Err <= 1'b0;
        end else begin
            Timeout_Err <= 1'b0;
            case (r_state)
                ST_IDLE, ST_GAP: begin
                    if (w_valid) begin
                        r_state <= ST_GRANT;
                        Grant   <= idx_to_onehot(w_win);
                        Y       <= w_win;
                        V       <= 1'b1;
                        r_cnt   <= CW'(1);
                        r_ptr   <= w_win + 2'd1;
                    end else begin
                        r_state <= ST_IDLE;
                        Grant   <= '0;
                        Y       <= 2'd0;
                        V       <= 1'b0;
                    end
                end
                ST_GRANT: begin
                    // Release wins over a coincident timeout.
                    if (!Req[Y]) begin
                        r_state <= ST_GAP;
                        Grant   <= '0;
                        Y       <= 2'd0;
                        V       <= 1'b0;
                    end else if (TIMEOUT != 0 && r_cnt == TO_CNT) begin
                        r_state     <= ST_GAP;
                        Grant       <= '0;
                        Y           <= 2'd0;
                        V           <= 1'b0;
                        Timeout_Err <= 1'b1;
                    end else if (r_cnt != CNT_MAX) begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    Grant   <= '0;
                    Y       <= 2'd0;
                    V       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter4.sv
// Self-checking bench for bus_arbiter4: three instances (round-robin/fixed with
// a short timeout, round-robin with timeout disabled) against a behavioural model.
module tb_bus_arbiter4;

    logic            clk = 1'b0;
    logic            rst;
    logic [3:0]      Req;
    logic [2:0][3:0] g;
    logic [2:0][1:0] y;
    logic [2:0]      v;
    logic [2:0]      te;

    int n_checks = 0;
    int n_errors = 0;

    int m_own [3];
    int m_cnt [3];
    int m_ptr [3];
    bit m_te  [3];

    typedef struct {
        logic [3:0] req;
        logic [3:0] grant;
        logic [1:0] y;
        logic       te;
    } vec_t;
    vec_t tbl [21];

    int order [5] = '{0, 1, 2, 3, 0};

    always #5 clk = ~clk;

    bus_arbiter4 #(.TIMEOUT(4), .ROTATE(1'b1)) u0 (
        .clk(clk), .rst(rst), .Req(Req), .Grant(g[0]), .Y(y[0]), .V(v[0]), .Timeout_Err(te[0]));
    bus_arbiter4 #(.TIMEOUT(4), .ROTATE(1'b0)) u1 (
        .clk(clk), .rst(rst), .Req(Req), .Grant(g[1]), .Y(y[1]), .V(v[1]), .Timeout_Err(te[1]));
    bus_arbiter4 #(.TIMEOUT(0), .ROTATE(1'b1)) u2 (
        .clk(clk), .rst(rst), .Req(Req), .Grant(g[2]), .Y(y[2]), .V(v[2]), .Timeout_Err(te[2]));

    function automatic int to_of(input int k);
        return (k == 2) ? 0 : 4;
    endfunction

    function automatic bit rot_of(input int k);
        return (k != 1);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_own[k] = -1;
            m_cnt[k] = 0;
            m_ptr[k] = 0;
            m_te[k]  = 1'b0;
        end
    endtask

    // One clock edge of the reference: owner/gap/pointer bookkeeping in plain ints.
    task automatic model_step(input logic [3:0] r);
        int w;
        int j;
        for (int k = 0; k < 3; k++) begin
            if (m_own[k] >= 0) begin
                if (!r[m_own[k]]) begin
                    m_own[k] = -1;
                    m_te[k]  = 1'b0;
                end else if (to_of(k) != 0 && m_cnt[k] == to_of(k)) begin
                    m_own[k] = -1;
                    m_te[k]  = 1'b1;
                end else begin
                    m_cnt[k] = m_cnt[k] + 1;
                    m_te[k]  = 1'b0;
                end
            end else begin
                m_te[k] = 1'b0;
                if (r != 4'b0000) begin
                    w = -1;
                    for (int i = 0; i < 4; i++) begin
                        j = rot_of(k) ? (m_ptr[k] + i) % 4 : i;
                        if (w < 0 && r[j]) w = j;
                    end
                    m_own[k] = w;
                    m_cnt[k] = 1;
                    m_ptr[k] = (w + 1) % 4;
                end
            end
        end
    endtask

    task automatic check_all();
        int eg;
        int ey;
        int idx;
        for (int k = 0; k < 3; k++) begin
            eg = (m_own[k] >= 0) ? (1 << m_own[k]) : 0;
            ey = (m_own[k] >= 0) ? m_own[k] : 0;
            chk($sformatf("u%0d_grant", k), int'(g[k]), eg);
            chk($sformatf("u%0d_y", k), int'(y[k]), ey);
            chk($sformatf("u%0d_v", k), int'(v[k]), (m_own[k] >= 0) ? 1 : 0);
            chk($sformatf("u%0d_timeout_err", k), int'(te[k]), int'(m_te[k]));
            chk($sformatf("u%0d_inv_onehot", k), ($countones(g[k]) <= 1) ? 1 : 0, 1);
            chk($sformatf("u%0d_inv_v", k), int'(v[k]), (g[k] != 4'b0000) ? 1 : 0);
            idx = 0;
            for (int i = 0; i < 4; i++) if (g[k][i]) idx = i;
            chk($sformatf("u%0d_inv_y", k), int'(y[k]), idx);
        end
    endtask

    // Drive Req before the edge, step the model on the edge, compare on the falling edge.
    task automatic cycle(input logic [3:0] r);
        Req = r;
        @(posedge clk);
        model_step(r);
        @(negedge clk);
        check_all();
    endtask

    // Asynchronous reset pulse placed between clock edges; outputs must clear at once.
    task automatic do_reset();
        #1 rst = 1'b1;
        #1;
        model_reset();
        check_all();
        chk("rst_grant_now", int'(g[0]), 0);
        chk("rst_v_now", int'(v[0]), 0);
        chk("rst_y_now", int'(y[0]), 0);
        #1 rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] r;

        tbl[0]  = '{4'b1110, 4'b0010, 2'd1, 1'b0};
        tbl[1]  = '{4'b1110, 4'b0010, 2'd1, 1'b0};
        tbl[2]  = '{4'b1100, 4'b0000, 2'd0, 1'b0};
        tbl[3]  = '{4'b1100, 4'b0100, 2'd2, 1'b0};
        tbl[4]  = '{4'b1100, 4'b0100, 2'd2, 1'b0};
        tbl[5]  = '{4'b1100, 4'b0100, 2'd2, 1'b0};
        tbl[6]  = '{4'b1100, 4'b0100, 2'd2, 1'b0};
        tbl[7]  = '{4'b1100, 4'b0000, 2'd0, 1'b1};
        tbl[8]  = '{4'b1100, 4'b0100, 2'd2, 1'b0};
        tbl[9]  = '{4'b0001, 4'b0000, 2'd0, 1'b0};
        tbl[10] = '{4'b0001, 4'b0001, 2'd0, 1'b0};
        tbl[11] = '{4'b0001, 4'b0001, 2'd0, 1'b0};
        tbl[12] = '{4'b0001, 4'b0001, 2'd0, 1'b0};
        tbl[13] = '{4'b0001, 4'b0001, 2'd0, 1'b0};
        tbl[14] = '{4'b0000, 4'b0000, 2'd0, 1'b0};
        tbl[15] = '{4'b0000, 4'b0000, 2'd0, 1'b0};
        tbl[16] = '{4'b0001, 4'b0001, 2'd0, 1'b0};
        tbl[17] = '{4'b1001, 4'b0001, 2'd0, 1'b0};
        tbl[18] = '{4'b1001, 4'b0001, 2'd0, 1'b0};
        tbl[19] = '{4'b1000, 4'b0000, 2'd0, 1'b0};
        tbl[20] = '{4'b1000, 4'b1000, 2'd3, 1'b0};

        rst = 1'b1;
        Req = 4'b0000;
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        rst = 1'b0;

        // Reset in the middle of a grant, then a fresh grant one clock after request.
        cycle(4'b0100);
        chk("t1_grant_before_rst", int'(g[0]), 4);
        do_reset();
        cycle(4'b0001);
        chk("t1_grant_after_rst", int'(g[0]), 1);

        // Fixed-priority sequence: release gap, timeout, release on cnt==TIMEOUT, no preemption.
        do_reset();
        for (int i = 0; i < 21; i++) begin
            cycle(tbl[i].req);
            chk($sformatf("tbl%0d_grant", i), int'(g[1]), int'(tbl[i].grant));
            chk($sformatf("tbl%0d_y", i), int'(y[1]), int'(tbl[i].y));
            chk($sformatf("tbl%0d_timeout_err", i), int'(te[1]), int'(tbl[i].te));
        end

        // Round-robin: each owner drops for one cycle after its grant.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cycle(4'b1111);
            chk($sformatf("rr%0d_grant", i), int'(g[0]), 1 << order[i]);
            cycle(4'b1111 & ~(4'b0001 << order[i]));
            chk($sformatf("rr%0d_gap", i), int'(g[0]), 0);
        end

        // Timeout disabled: grant held indefinitely.
        do_reset();
        for (int i = 0; i < 20; i++) cycle(4'b0010);
        chk("noto_grant_held", int'(g[2]), 2);
        chk("noto_no_err", int'(te[2]), 0);

        // Random soak with slowly changing requests and occasional resets.
        do_reset();
        r = 4'($urandom);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) r = r ^ (4'b0001 << $urandom_range(0, 3));
            if ($urandom_range(0, 299) == 0) do_reset();
            cycle(r);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
